vsync_irq_gen: RTL

Frame-interrupt source for the QL core. Sits between the ZX8301 video timing output and the ZX8302 interrupt status register. It synchronises the raw vertical sync into `clk`, deglitches it, detects qualified rising edges and holds a pending frame interrupt until the CPU acknowledges it. It also maintains a frame counter and, optionally, an overrun counter. This replaces the latch clocked directly by `vs` with fully `clk`-synchronous logic.

---
 rtl/vsync_irq_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/vsync_irq_gen.sv
// Frame-interrupt source: synchronises and deglitches vertical sync, then raises a pending
// frame interrupt on each qualified rising edge. Optional overrun counter: VSYNC_IRQ_OVERRUN_EN.
module vsync_irq_gen #(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             vsync_irq_reset,
    input  logic             vs_in,
    input  logic             irq_ack,
    output logic             irq,
    output logic             vs_edge,
    output logic             vs_level,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       overrun_cnt
);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } filt_state_t;

    localparam logic [8:0] FILT_TGT = 9'(FILTER_LEN);

    logic        s1;
    logic        s2;
    filt_state_t state;
    filt_state_t state_nxt;
    logic [7:0]  qcnt;
    logic [7:0]  qcnt_nxt;
    logic [8:0]  qcnt_inc;
    logic        qual;
    logic        rise;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge vsync_irq_reset) begin
        if (vsync_irq_reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= vs_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge vsync_irq_reset) begin
        if (vsync_irq_reset) begin
            state <= LOW;
            qcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
        end
    end

    // Qualifying level is the one opposite to the currently accepted level.
    assign qual     = (state == LOW) ? s2 : ~s2;
    assign qcnt_inc = {1'b0, qcnt} + 9'd1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = 8'd0;
        rise      = 1'b0;
        if (qual) begin
            if (qcnt_inc == FILT_TGT) begin
                state_nxt = (state == LOW) ? HIGH : LOW;
                rise      = (state == LOW);
            end else begin
                qcnt_nxt = qcnt_inc[7:0];
            end
        end
    end

    assign vs_level = (state == HIGH);

    always_ff @(posedge clk or posedge vsync_irq_reset) begin
        if (vsync_irq_reset) begin
            vs_edge   <= 1'b0;
            irq       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_edge <= rise;
            if (rise) begin
                // A new frame wins over a simultaneous acknowledge.
                irq       <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef VSYNC_IRQ_OVERRUN_EN
    logic [7:0] ovr_q;

    always_ff @(posedge clk or posedge vsync_irq_reset) begin
        if (vsync_irq_reset) begin
            ovr_q <= 8'd0;
        end else if (rise && irq && !irq_ack && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 8'h00;
`endif

endmodule
